// File: rtl/imem_arbiter.sv
// Instruction ROM arbiter: shares one combinational ROM between the fetch path
// and a debug read port, with fetch priority, starvation bound and debug lock.
module imem_arbiter #(
  parameter int          DEPTH    = 23,
  parameter int          MAX_WAIT = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [30:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [30:0] d_addr,
  input  logic        d_lock,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [30:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  fsm_state
);

  // Handshake: a requester holds req and addr stable until it sees gnt in the
  // same cycle; each gnt yields exactly one rvalid pulse on the following cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DEBUG = 2'd2,
    DLOCK = 2'd3
  } state_t;

  localparam logic [3:0] MAXW    = 4'(MAX_WAIT);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        oor;
  logic [31:0] word;

  assign fsm_state = state_q;

  always_comb begin
    d_gnt    = 1'b0;
    f_gnt    = 1'b0;
    mem_addr = '0;
    state_d  = state_q;
    starve_d = starve_q;

    // Grants are forced low while reset is asserted.
    if (reset) begin
      d_gnt = d_req && (state_q == DLOCK || !f_req || starve_q == MAXW);
      f_gnt = f_req && !d_gnt;
    end

    if (d_gnt)      mem_addr = d_addr;
    else if (f_gnt) mem_addr = f_addr;

    if (state_q == DLOCK) begin
      if (d_lock && d_req) state_d = DLOCK;
      else if (f_req)      state_d = FETCH;
      else                 state_d = IDLE;
    end else if (d_gnt && d_lock) begin
      state_d = DLOCK;
    end else if (d_gnt) begin
      state_d = DEBUG;
    end else if (f_gnt) begin
      state_d = FETCH;
    end else begin
      state_d = IDLE;
    end

    if (d_gnt || !d_req)                   starve_d = 4'd0;
    else if (f_gnt && starve_q != MAXW)    starve_d = starve_q + 4'd1;
  end

  // The ROM word index is bits [9:2]; anything at or past DEPTH reads as NOP.
  assign oor  = {1'b0, mem_addr[9:2]} >= DEPTH_W;
  assign word = oor ? NOP_WORD : mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt && oor;
      if (f_gnt) f_rdata <= word;
      if (d_gnt) d_rdata <= word;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: driver issues vectors and queues expected
// responses; a negedge monitor pops and compares whenever rvalid is seen.
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [30:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [30:0] d_addr;
  logic        d_lock;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [30:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] f_exp_q[$];
  int          f_cyc_q[$];
  logic [32:0] d_exp_q[$];
  int          d_cyc_q[$];
  logic [31:0] f_last = '0;
  logic [31:0] d_last = '0;

  imem_arbiter #(.DEPTH(23), .MAX_WAIT(4), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_lock(d_lock), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  // ROM model: index 23 holds a non-NOP word so range clamping is visible.
  always_comb begin
    case (mem_addr[9:2])
      8'd0:    mem_rdata = 32'h0800_0003;
      8'd1:    mem_rdata = 32'h0c00_0015;
      8'd2:    mem_rdata = 32'h0800_0016;
      8'd3:    mem_rdata = 32'h0040_0093;
      8'd4:    mem_rdata = 32'h0010_8113;
      8'd22:   mem_rdata = 32'h1000_ffff;
      8'd23:   mem_rdata = 32'hdead_beef;
      default: mem_rdata = {24'hee0000, mem_addr[9:2]};
    endcase
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests, check grants and ROM address, queue the response.
  task automatic step(input logic fr, input logic [30:0] fa,
                      input logic dr, input logic [30:0] da, input logic dl,
                      input logic ef, input logic ed,
                      input logic [31:0] edata, input logic eerr);
    logic [30:0] ea;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_lock = dl;
    @(negedge clk);
    ea = ed ? da : (ef ? fa : 31'd0);
    chk("f_gnt", {63'd0, f_gnt}, {63'd0, ef});
    chk("d_gnt", {63'd0, d_gnt}, {63'd0, ed});
    chk("mem_addr", {33'd0, mem_addr}, {33'd0, ea});
    if (ef) begin f_exp_q.push_back(edata); f_cyc_q.push_back(cyc + 1); end
    if (ed) begin d_exp_q.push_back({eerr, edata}); d_cyc_q.push_back(cyc + 1); end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 31'd0, 1'b0, 31'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_gnt"},    {63'd0, f_gnt},    64'd0);
    chk({tag, "_d_gnt"},    {63'd0, d_gnt},    64'd0);
    chk({tag, "_f_rvalid"}, {63'd0, f_rvalid}, 64'd0);
    chk({tag, "_d_rvalid"}, {63'd0, d_rvalid}, 64'd0);
    chk({tag, "_d_err"},    {63'd0, d_err},    64'd0);
    chk({tag, "_f_rdata"},  {32'd0, f_rdata},  64'd0);
    chk({tag, "_d_rdata"},  {32'd0, d_rdata},  64'd0);
    chk({tag, "_mem_addr"}, {33'd0, mem_addr}, 64'd0);
    chk({tag, "_state"},    {62'd0, fsm_state}, 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (f_rvalid) begin
        if (f_exp_q.size() == 0) chk("f_unexpected_rvalid", 64'd1, 64'd0);
        else begin
          logic [31:0] e;
          int c;
          e = f_exp_q.pop_front();
          c = f_cyc_q.pop_front();
          chk("f_rdata", {32'd0, f_rdata}, {32'd0, e});
          chk("f_latency", 64'(cyc), 64'(c));
          f_last = e;
        end
      end else begin
        chk("f_rdata_hold", {32'd0, f_rdata}, {32'd0, f_last});
      end
      if (d_rvalid) begin
        if (d_exp_q.size() == 0) chk("d_unexpected_rvalid", 64'd1, 64'd0);
        else begin
          logic [32:0] e;
          int c;
          e = d_exp_q.pop_front();
          c = d_cyc_q.pop_front();
          chk("d_rdata", {32'd0, d_rdata}, {32'd0, e[31:0]});
          chk("d_err", {63'd0, d_err}, {63'd0, e[32]});
          chk("d_latency", 64'(cyc), 64'(c));
          d_last = e[31:0];
        end
      end else begin
        chk("d_rdata_hold", {32'd0, d_rdata}, {32'd0, d_last});
        chk("d_err_idle", {63'd0, d_err}, 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_addr = '0; d_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    // 1: fetch only, back-to-back
    step(1'b1, 31'h0, 1'b0, 31'h0, 1'b0, 1'b1, 1'b0, 32'h0800_0003, 1'b0);
    step(1'b1, 31'h4, 1'b0, 31'h0, 1'b0, 1'b1, 1'b0, 32'h0c00_0015, 1'b0);
    step(1'b1, 31'h8, 1'b0, 31'h0, 1'b0, 1'b1, 1'b0, 32'h0800_0016, 1'b0);
    idle();

    // 2: contention, debug wins after MAX_WAIT fetch wins
    step(1'b1, 31'hc,  1'b1, 31'h4, 1'b0, 1'b1, 1'b0, 32'h0040_0093, 1'b0);
    step(1'b1, 31'h10, 1'b1, 31'h4, 1'b0, 1'b1, 1'b0, 32'h0010_8113, 1'b0);
    step(1'b1, 31'hc,  1'b1, 31'h4, 1'b0, 1'b1, 1'b0, 32'h0040_0093, 1'b0);
    step(1'b1, 31'h10, 1'b1, 31'h4, 1'b0, 1'b1, 1'b0, 32'h0010_8113, 1'b0);
    step(1'b1, 31'hc,  1'b1, 31'h4, 1'b0, 1'b0, 1'b1, 32'h0c00_0015, 1'b0);
    step(1'b1, 31'hc,  1'b1, 31'h4, 1'b0, 1'b1, 1'b0, 32'h0040_0093, 1'b0);
    idle();

    // 3: locked debug burst; starve must have restarted from 0
    for (int i = 0; i < 4; i++)
      step(1'b1, 31'hc, 1'b1, 31'h0, 1'b1, 1'b1, 1'b0, 32'h0040_0093, 1'b0);
    step(1'b1, 31'hc, 1'b1, 31'h0, 1'b1, 1'b0, 1'b1, 32'h0800_0003, 1'b0);
    chk("state_dlock", {62'd0, fsm_state}, 64'd3);
    step(1'b1, 31'hc, 1'b1, 31'h4, 1'b1, 1'b0, 1'b1, 32'h0c00_0015, 1'b0);
    step(1'b1, 31'hc, 1'b1, 31'h8, 1'b1, 1'b0, 1'b1, 32'h0800_0016, 1'b0);
    step(1'b1, 31'h10, 1'b0, 31'h0, 1'b0, 1'b1, 1'b0, 32'h0010_8113, 1'b0);
    idle();

    // 4/5: range boundary on both ports, and index taken from bits [9:2] only
    step(1'b0, 31'h0,   1'b1, 31'h5c, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    step(1'b1, 31'h5c,  1'b0, 31'h0,  1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
    step(1'b0, 31'h0,   1'b1, 31'h58, 1'b0, 1'b0, 1'b1, 32'h1000_ffff, 1'b0);
    step(1'b1, 31'h404, 1'b0, 31'h0,  1'b0, 1'b1, 1'b0, 32'h0c00_0015, 1'b0);
    step(1'b1, 31'h58,  1'b1, 31'h5c, 1'b0, 1'b1, 1'b0, 32'h1000_ffff, 1'b0);
    idle();

    // 6: async reset while locked with a response on the outputs
    step(1'b0, 31'h0, 1'b1, 31'h4, 1'b1, 1'b0, 1'b1, 32'h0c00_0015, 1'b1 & 1'b0);
    f_req = 1'b1; f_addr = 31'h8; d_req = 1'b1; d_addr = 31'h8; d_lock = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    f_exp_q.delete(); f_cyc_q.delete(); d_exp_q.delete(); d_cyc_q.delete();
    f_last = '0; d_last = '0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    reset = 1'b1;
    step(1'b1, 31'h8, 1'b1, 31'h4, 1'b0, 1'b1, 1'b0, 32'h0800_0016, 1'b0);
    step(1'b1, 31'hc, 1'b1, 31'h4, 1'b0, 1'b1, 1'b0, 32'h0040_0093, 1'b0);
    idle();
    idle();

    chk("f_queue_drained", 64'(f_exp_q.size()), 64'd0);
    chk("d_queue_drained", 64'(d_exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
